pingpong_ram_bank: RTL and testbench

Double-buffered (ping-pong) banked RAM for the encoder datapath. A producer fills one buffer frame with masked per-bank writes while a consumer drains the other. Ownership swaps on explicit last-beat markers. Successor to the single-buffer bank: it adds buffer state tracking, write/read handshakes, a read-data-valid pipeline, and selectable slice/broadcast write mode.

---
 rtl/pingpong_ram_bank.sv | 171 +++++++++++++++++
 tb/tb_pingpong_ram_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_ram_bank.sv
// pingpong_ram_bank
// Double-buffered banked RAM. A producer fills one buffer frame with masked
// per-bank writes while a consumer drains the other frame. Ownership of a
// buffer passes between the two sides on last-beat markers.
//
// Optional feature macro: PPBUF_ERR_CHECK_EN. When it is defined, err_o is a
// sticky flag for requests that arrive while the addressed side is not
// accepting. When it is undefined, err_o is tied low.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   wr_valid_i        write beat valid
//   wr_ready_o        current write buffer is EMPTY and accepting beats
//   wr_addr_i         write word address
//   wr_data_i         write data (slice per bank, or lane 0 broadcast)
//   wr_mask_i         per-bank write enable
//   wr_last_i         final beat of the frame; hands the buffer to the reader
//   rd_avail_o        current read buffer is FULL
//   rd_en_i           read request
//   rd_addr_i         read word address
//   rd_last_i         final read of the frame; hands the buffer back to the writer
//   rd_data_o         read data, LATENCY cycles after the read fires
//   rd_data_valid_o   qualifies rd_data_o
//   err_o             sticky protocol error
//
// Handshake: a write beat fires when wr_valid_i & wr_ready_o, and a read fires
// when rd_en_i & rd_avail_o. A request that does not fire has no effect on
// the RAMs or on buffer state. Both ready-style outputs are decoded only from
// registered state, so they never depend combinationally on the requests.
module pingpong_ram_bank #(
    parameter int BANK_DATA_WIDTH = 512,
    parameter int BANK_NUM        = 8,
    parameter int ADDR_WIDTH      = 10,
    parameter int LATENCY         = 1,
    parameter int BROADCAST       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [ADDR_WIDTH-1:0]      wr_addr_i,
    input  logic [BANK_DATA_WIDTH-1:0] wr_data_i,
    input  logic [BANK_NUM-1:0]        wr_mask_i,
    input  logic                       wr_last_i,
    output logic                       rd_avail_o,
    input  logic                       rd_en_i,
    input  logic [ADDR_WIDTH-1:0]      rd_addr_i,
    input  logic                       rd_last_i,
    output logic [BANK_DATA_WIDTH-1:0] rd_data_o,
    output logic                       rd_data_valid_o,
    output logic                       err_o
);

    localparam int DATA_WIDTH = BANK_DATA_WIDTH / BANK_NUM;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    buf_state_e state_q [2];
    buf_state_e state_d [2];
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;

    logic wr_fire;
    logic rd_fire;

    logic [BANK_DATA_WIDTH-1:0] rd_word;
    logic [BANK_DATA_WIDTH-1:0] pipe_data_q [LATENCY];
    logic [LATENCY-1:0]         pipe_vld_q;

    assign wr_ready_o = (state_q[wr_sel_q] == BUF_EMPTY);
    assign rd_avail_o = (state_q[rd_sel_q] == BUF_FULL);
    assign wr_fire    = wr_valid_i & wr_ready_o;
    assign rd_fire    = rd_en_i & rd_avail_o;

    // A write-last and a read-last in the same cycle always target different
    // buffers (one must be EMPTY, the other FULL), so both updates apply.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        if (wr_fire && wr_last_i) begin
            state_d[wr_sel_q] = BUF_FULL;
            wr_sel_d          = ~wr_sel_q;
        end
        if (rd_fire && rd_last_i) begin
            state_d[rd_sel_q] = BUF_EMPTY;
            rd_sel_d          = ~rd_sel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0] <= BUF_EMPTY;
            state_q[1] <= BUF_EMPTY;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    // One RAM per bank holding both buffers; the buffer select is the top
    // index. RAM contents are deliberately not reset.
    for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];
        logic [DATA_WIDTH-1:0] wdata;

        if (BROADCAST != 0) begin : g_bcast
            assign wdata = wr_data_i[DATA_WIDTH-1:0];
        end else begin : g_slice
            assign wdata = wr_data_i[g*DATA_WIDTH +: DATA_WIDTH];
        end

        always_ff @(posedge clk) begin
            if (wr_fire && wr_mask_i[g]) begin
                mem_q[wr_sel_q][wr_addr_i] <= wdata;
            end
        end

        assign rd_word[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_sel_q][rd_addr_i];
    end

    // Stage 0 is the synchronous RAM read; further stages pad the latency.
    // The pipeline shifts every cycle, so reads issued before a read-last
    // still come out in order after the buffer swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_data_q[k] <= '0;
            end
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= rd_fire;
            if (rd_fire) begin
                pipe_data_q[0] <= rd_word;
            end
            for (int k = 1; k < LATENCY; k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1];
                pipe_data_q[k] <= pipe_data_q[k-1];
            end
        end
    end

    assign rd_data_o       = pipe_data_q[LATENCY-1];
    assign rd_data_valid_o = pipe_vld_q[LATENCY-1];

`ifdef PPBUF_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((wr_valid_i && !wr_ready_o) || (rd_en_i && !rd_avail_o)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_ram_bank.sv
// Testbench for pingpong_ram_bank. Main instance uses slice write mode with
// LATENCY=3; a second instance uses broadcast mode with LATENCY=1.
// The reference model counts frames written and frames read: buffer selects
// are the counts modulo 2 and the number of FULL buffers is their difference.
module tb_pingpong_ram_bank;

    localparam int AW  = 4;
    localparam int LAT = 3;
    localparam int NB  = 8;
    localparam int W   = 512;
    localparam int DW  = W / NB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [NB-1:0] wr_mask = '0;
    logic          wr_last = 1'b0;
    logic          rd_avail;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_last = 1'b0;
    logic [W-1:0]  rd_data;
    logic          rd_data_valid;
    logic          err;

    logic          b_wr_valid = 1'b0;
    logic          b_wr_ready;
    logic [AW-1:0] b_wr_addr = '0;
    logic [W-1:0]  b_wr_data = '0;
    logic [NB-1:0] b_wr_mask = '0;
    logic          b_wr_last = 1'b0;
    logic          b_rd_avail;
    logic          b_rd_en = 1'b0;
    logic [AW-1:0] b_rd_addr = '0;
    logic          b_rd_last = 1'b0;
    logic [W-1:0]  b_rd_data;
    logic          b_rd_data_valid;
    logic          b_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model
    logic [DW-1:0] ref_mem [2][NB][1<<AW];
    int            wcnt    = 0;
    int            rcnt    = 0;
    logic          err_exp = 1'b0;
    logic [W-1:0]  exp_q [$];
    int            due_q [$];

    pingpong_ram_bank #(
        .BANK_DATA_WIDTH(W), .BANK_NUM(NB), .ADDR_WIDTH(AW),
        .LATENCY(LAT), .BROADCAST(0)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_mask_i(wr_mask), .wr_last_i(wr_last),
        .rd_avail_o(rd_avail), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_last_i(rd_last), .rd_data_o(rd_data),
        .rd_data_valid_o(rd_data_valid), .err_o(err)
    );

    pingpong_ram_bank #(
        .BANK_DATA_WIDTH(W), .BANK_NUM(NB), .ADDR_WIDTH(AW),
        .LATENCY(1), .BROADCAST(1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .wr_valid_i(b_wr_valid), .wr_ready_o(b_wr_ready), .wr_addr_i(b_wr_addr),
        .wr_data_i(b_wr_data), .wr_mask_i(b_wr_mask), .wr_last_i(b_wr_last),
        .rd_avail_o(b_rd_avail), .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr),
        .rd_last_i(b_rd_last), .rd_data_o(b_rd_data),
        .rd_data_valid_o(b_rd_data_valid), .err_o(b_err)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-return scoreboard: every cycle out of reset, rd_data_valid must be
    // high exactly when a read is due, carrying the expected word.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                if (rd_data_valid !== 1'b1 || rd_data !== exp_q[0])
                    $display("FAIL rd_return cyc=%0d: valid=%b data=%h required valid=1 data=%h",
                             cyc, rd_data_valid, rd_data, exp_q[0]);
                else
                    n_pass++;
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end else begin
                if (rd_data_valid !== 1'b0)
                    $display("FAIL rd_spurious_valid cyc=%0d: valid=%b required 0", cyc, rd_data_valid);
                else
                    n_pass++;
            end
        end
    end

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Driver: applies one cycle of requests and advances the model.
    task automatic step(input logic wv, input logic wl, input logic [AW-1:0] wa,
                        input logic [W-1:0] wd, input logic [NB-1:0] wm,
                        input logic re, input logic rl, input logic [AW-1:0] ra);
        logic         wf, rf;
        logic [W-1:0] rexp;
        wr_valid = wv; wr_last = wl; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_en = re; rd_last = rl; rd_addr = ra;
        wf = wv && ((wcnt - rcnt) < 2);
        rf = re && ((wcnt - rcnt) > 0);
`ifdef PPBUF_ERR_CHECK_EN
        if ((wv && !wf) || (re && !rf)) err_exp = 1'b1;
`endif
        for (int i = 0; i < NB; i++) rexp[i*DW +: DW] = ref_mem[rcnt % 2][i][ra];
        @(posedge clk);
        #1;
        if (wf) begin
            for (int i = 0; i < NB; i++)
                if (wm[i]) ref_mem[wcnt % 2][i][wa] = wd[i*DW +: DW];
            if (wl) wcnt++;
        end
        if (rf) begin
            exp_q.push_back(rexp);
            due_q.push_back(cyc + LAT - 1);
            if (rl) rcnt++;
        end
        wr_valid = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_last = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b required 1", wr_ready); else n_pass++;
        n_checks++; if (rd_avail !== 1'b0) $display("FAIL reset_rd_avail: got %b required 0", rd_avail); else n_pass++;
        n_checks++; if (rd_data_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b required 0", rd_data_valid); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %h required 0", rd_data); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b required 0", err); else n_pass++;
    endtask

    task automatic test_basic();
        for (int a = 0; a < 4; a++) begin
            step(1'b1, (a == 3), a[AW-1:0], rand_word(), 8'hFF, 1'b0, 1'b0, '0);
            if (a < 3) begin
                n_checks++;
                if (rd_avail !== 1'b0) $display("FAIL basic_no_bypass a=%0d: got %b required 0", a, rd_avail); else n_pass++;
            end
        end
        n_checks++; if (rd_avail !== 1'b1) $display("FAIL basic_rd_avail: got %b required 1", rd_avail); else n_pass++;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL basic_wr_ready: got %b required 1", wr_ready); else n_pass++;
        for (int a = 0; a < 4; a++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, (a == 3), a[AW-1:0]);
        n_checks++; if (rd_avail !== 1'b0) $display("FAIL basic_rd_avail_after_last: got %b required 0", rd_avail); else n_pass++;
        idle(LAT + 1);
    endtask

    task automatic test_fill_both();
        for (int f = 0; f < 2; f++) begin
            for (int a = 0; a < 16; a++)
                step(1'b1, (a == 15), a[AW-1:0], rand_word(), 8'hFF, 1'b0, 1'b0, '0);
            n_checks++;
            if (wr_ready !== (f == 0)) $display("FAIL fill_wr_ready f=%0d: got %b required %b", f, wr_ready, (f == 0)); else n_pass++;
        end
        n_checks++; if (rd_avail !== 1'b1) $display("FAIL fill_rd_avail: got %b required 1", rd_avail); else n_pass++;
        // Beat offered while both buffers are full must not land anywhere.
        step(1'b1, 1'b1, '0, rand_word(), 8'hFF, 1'b0, 1'b0, '0);
        n_checks++; if (wr_ready !== 1'b0) $display("FAIL fill_extra_wr_ready: got %b required 0", wr_ready); else n_pass++;
        n_checks++; if (err !== err_exp) $display("FAIL fill_err: got %b required %b", err, err_exp); else n_pass++;
        for (int f = 0; f < 2; f++)
            for (int a = 0; a < 16; a++)
                step(1'b0, 1'b0, '0, '0, '0, 1'b1, (a == 15), a[AW-1:0]);
        n_checks++; if (rd_avail !== 1'b0) $display("FAIL drain_rd_avail: got %b required 0", rd_avail); else n_pass++;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL drain_wr_ready: got %b required 1", wr_ready); else n_pass++;
        idle(LAT + 1);
    endtask

    task automatic test_same_cycle_swap();
        step(1'b1, 1'b0, 4'd0, rand_word(), 8'hFF, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 4'd1, rand_word(), 8'hFF, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 4'd0, rand_word(), 8'hFF, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 4'd1, rand_word(), 8'hFF, 1'b1, 1'b1, 4'd1);
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL swap_wr_ready: got %b required 1", wr_ready); else n_pass++;
        n_checks++; if (rd_avail !== 1'b1) $display("FAIL swap_rd_avail: got %b required 1", rd_avail); else n_pass++;
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 4'd1);
        idle(LAT + 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 7) == 0, AW'($urandom()),
                 rand_word(), NB'($urandom()),
                 $urandom_range(0, 99) < 60, $urandom_range(0, 5) == 0, AW'($urandom()));
            n_checks++;
            if (wr_ready !== ((wcnt - rcnt) < 2)) $display("FAIL rand_wr_ready n=%0d: got %b required %b", n, wr_ready, ((wcnt - rcnt) < 2)); else n_pass++;
            n_checks++;
            if (rd_avail !== ((wcnt - rcnt) > 0)) $display("FAIL rand_rd_avail n=%0d: got %b required %b", n, rd_avail, ((wcnt - rcnt) > 0)); else n_pass++;
            n_checks++;
            if (err !== err_exp) $display("FAIL rand_err n=%0d: got %b required %b", n, err, err_exp); else n_pass++;
        end
        idle(LAT + 1);
    endtask

    task automatic test_reset_midframe();
        logic exp_v;
        if (wcnt == rcnt) step(1'b1, 1'b1, '0, rand_word(), 8'hFF, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++)
            step(((wcnt - rcnt) < 2), 1'b0, AW'(i), rand_word(), 8'hFF, 1'b1, 1'b0, AW'(i));
        exp_v = (due_q.size() > 0 && due_q[0] == cyc);
        n_checks++; if (rd_data_valid !== exp_v) $display("FAIL pre_reset_valid: got %b required %b", rd_data_valid, exp_v); else n_pass++;
        rst = 1'b1;
        #1;
        wcnt = 0; rcnt = 0; err_exp = 1'b0;
        exp_q.delete(); due_q.delete();
        n_checks++; if (rd_data_valid !== 1'b0) $display("FAIL midreset_valid: got %b required 0", rd_data_valid); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL midreset_data: got %h required 0", rd_data); else n_pass++;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL midreset_wr_ready: got %b required 1", wr_ready); else n_pass++;
        n_checks++; if (rd_avail !== 1'b0) $display("FAIL midreset_rd_avail: got %b required 0", rd_avail); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL midreset_err: got %b required 0", err); else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(LAT + 2);
        n_checks++; if (rd_avail !== 1'b0) $display("FAIL post_reset_rd_avail: got %b required 0", rd_avail); else n_pass++;
        n_checks++; if (wr_ready !== 1'b1) $display("FAIL post_reset_wr_ready: got %b required 1", wr_ready); else n_pass++;
    endtask

    task automatic test_broadcast();
        logic [DW-1:0] d0;
        logic [W-1:0]  exp;
        d0 = {$urandom(), $urandom()};
        b_wr_valid = 1'b1; b_wr_addr = '0; b_wr_mask = 8'hFF; b_wr_last = 1'b0;
        b_wr_data = rand_word();
        b_wr_data[DW-1:0] = d0;
        @(posedge clk); #1;
        b_wr_mask = 8'h05; b_wr_last = 1'b1;
        b_wr_data = rand_word();
        b_wr_data[DW-1:0] = 64'hA5;
        @(posedge clk); #1;
        b_wr_valid = 1'b0; b_wr_last = 1'b0;
        n_checks++; if (b_rd_avail !== 1'b1) $display("FAIL bcast_rd_avail: got %b required 1", b_rd_avail); else n_pass++;
        b_rd_en = 1'b1; b_rd_addr = '0; b_rd_last = 1'b1;
        @(posedge clk); #1;
        b_rd_en = 1'b0; b_rd_last = 1'b0;
        for (int i = 0; i < NB; i++) exp[i*DW +: DW] = (i == 0 || i == 2) ? 64'hA5 : d0;
        n_checks++; if (b_rd_data_valid !== 1'b1) $display("FAIL bcast_valid: got %b required 1", b_rd_data_valid); else n_pass++;
        n_checks++; if (b_rd_data !== exp) $display("FAIL bcast_data: got %h required %h", b_rd_data, exp); else n_pass++;
        n_checks++; if (b_rd_avail !== 1'b0) $display("FAIL bcast_rd_avail_after_last: got %b required 0", b_rd_avail); else n_pass++;
        n_checks++; if (b_err !== 1'b0) $display("FAIL bcast_err: got %b required 0", b_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_both();
        test_same_cycle_swap();
        test_random();
        test_reset_midframe();
        test_broadcast();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
